regfile_fib_seq: RTL and testbench

Sequencer that drives the read and write ports of the 64x32 register file. It fills entries 2..N with the running sum `reg[i] = reg[i-2] + reg[i-1]`, starting from the seed values held in entries 0 and 1. It sits beside the register file: its `rAddr` output feeds the file's read address, and it takes the file's `rDout` back in. A start/busy/done handshake lets a top-level test harness or a front panel launch a fill run.

---
 rtl/regfile_fib_seq_pkg.sv | 26 ++
 rtl/regfile_fib_seq_if.sv | 31 +++
 rtl/regfile_fib_seq_add.sv | 28 ++
 rtl/regfile_fib_seq.sv | 161 ++++++++++++++++
 tb/tb_regfile_fib_seq.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_fib_seq_pkg.sv
// Shared types and constants for the register-file Fibonacci fill sequencer.
//   DW        : data width of a register-file word
//   AW        : register-file address width (64 entries)
//   SEED_BASE : first index written by a run (entries 0 and 1 hold the seeds)
//   state_e   : sequencer FSM states
//   wr_req_t  : write-port payload (address + data)
package fib_pkg;

  localparam int unsigned DW        = 32;
  localparam int unsigned AW        = 6;
  localparam int unsigned SEED_BASE = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_fib_seq_if.sv
// Launch handshake plus register-file read/write port of the fill sequencer.
//   start/count            : launch request and last index to write
//   rAddr/rDin             : register-file read port (rDin is combinational)
//   wAddr/wDin/wEna        : register-file write port
//   busy/done/overflow     : run status
// master = sequencer side, slave = harness / register-file side.
interface regfile_fib_seq_if;
  import fib_pkg::*;

  logic          start;
  logic [AW-1:0] count;
  logic [AW-1:0] rAddr;
  logic [DW-1:0] rDin;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wDin;
  logic          wEna;
  logic          busy;
  logic          done;
  logic          overflow;

  modport master (
    input  start, count, rDin,
    output rAddr, wAddr, wDin, wEna, busy, done, overflow
  );

  modport slave (
    output start, count, rDin,
    input  rAddr, wAddr, wDin, wEna, busy, done, overflow
  );

endinterface

// File: rtl/regfile_fib_seq_add.sv
// fib_add: DW-bit unsigned adder returning sum and carry-out.
//   a_i, b_i   : operands
//   sum_c_o    : sum (combinational); saturates to all-ones on carry when
//                FIB_SAT_EN is defined, otherwise wraps modulo 2^DW
//   carry_c_o  : carry-out of the unsaturated add (combinational)
// Build option: FIB_SAT_EN
module fib_add
  import fib_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] sum_c_o,
  output logic          carry_c_o
);

  logic [DW:0] full_c;

  // One extra bit exposes the carry-out.
  assign full_c    = {1'b0, a_i} + {1'b0, b_i};
  assign carry_c_o = full_c[DW];

`ifdef FIB_SAT_EN
  assign sum_c_o = carry_c_o ? {DW{1'b1}} : full_c[DW-1:0];
`else
  assign sum_c_o = full_c[DW-1:0];
`endif

endmodule

// File: rtl/regfile_fib_seq.sv
// regfile_fib_seq: fills register-file entries 2..count with
// reg[i] = reg[i-2] + reg[i-1], reading through rAddr/rDin and writing
// through wAddr/wDin/wEna. Three cycles per element (RD_A, RD_B, WR).
//   clk   : rising-edge clock (register file writes on the falling edge)
//   rst_n : asynchronous active-low reset, shared with the register file
//   bus   : regfile_fib_seq_if.master (handshake, read port, write port)
// All bus outputs are registered; the output stage is fed from the
// next-state values so each output is valid for the whole state it belongs to.
// Build option: FIB_SAT_EN (saturating add, applied inside fib_add).
module regfile_fib_seq
  import fib_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  regfile_fib_seq_if.master   bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;

  logic [AW-1:0] r_addr_q, r_addr_d;
  wr_req_t       wr_q, wr_d;
  logic          w_ena_q, w_ena_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] sum_c;
  logic          carry_c;

  // Operand b comes from b_d so the sum is ready on the edge entering WR.
  fib_add u_add (
    .a_i       (a_q),
    .b_i       (b_d),
    .sum_c_o   (sum_c),
    .carry_c_o (carry_c)
  );

  // State register with index counter and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.count >= AW'(SEED_BASE)) begin
            state_d = RD_A;
            cnt_d   = bus.count;
            i_d     = AW'(SEED_BASE);
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_A: begin
        a_d     = bus.rDin;
        state_d = RD_B;
      end
      RD_B: begin
        b_d     = bus.rDin;
        state_d = WR;
      end
      WR: begin
        if (i_q == cnt_q) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + AW'(1);
          state_d = RD_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: values the outputs take in the state being entered.
  always_comb begin
    r_addr_d = r_addr_q;
    wr_d     = wr_q;
    w_ena_d  = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    // A start with count >= 2 begins a new run and clears the sticky flag.
    if ((state_q == IDLE) && (state_d == RD_A)) begin
      ovf_d = 1'b0;
    end
    case (state_d)
      RD_A: begin
        busy_d   = 1'b1;
        r_addr_d = i_d - AW'(2);
      end
      RD_B: begin
        busy_d   = 1'b1;
        r_addr_d = i_d - AW'(1);
      end
      WR: begin
        busy_d    = 1'b1;
        w_ena_d   = 1'b1;
        wr_d.addr = i_d;
        wr_d.data = sum_c;
        if (carry_c) begin
          ovf_d = 1'b1;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Output registers; reset clears wEna and busy without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q <= '0;
      wr_q     <= '0;
      w_ena_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      r_addr_q <= r_addr_d;
      wr_q     <= wr_d;
      w_ena_q  <= w_ena_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.rAddr    = r_addr_q;
  assign bus.wAddr    = wr_q.addr;
  assign bus.wDin     = wr_q.data;
  assign bus.wEna     = w_ena_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_regfile_fib_seq.sv
// Bench for regfile_fib_seq: behavioural 64x32 register file (falling-edge
// write, async reset to the seed values) plus an array-based reference model.
module tb_regfile_fib_seq;
  import fib_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_fib_seq_if bus ();
  regfile_fib_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  // Register file model
  logic [DW-1:0] mem [64];
  logic [DW-1:0] seed0 = 32'd2;
  logic [DW-1:0] seed1 = 32'd2;
  assign bus.rDin = mem[bus.rAddr];
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) mem[k] <= '0;
      mem[0] <= seed0;
      mem[1] <= seed1;
    end else if (bus.wEna) begin
      mem[bus.wAddr] <= bus.wDin;
    end
  end

  // Reference model: expected contents and expected write stream
  logic [DW-1:0] mdl [64];
  logic          mdl_ovf;
  int            exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_ovf  [$];

  // Observed run
  int            cap_addr [$];
  logic [DW-1:0] cap_data [$];
  logic          cap_ovf  [$];
  int            busy_cyc, done_n, done_at;
  logic          ovf_any;

  task automatic model_reset();
    for (int k = 0; k < 64; k++) mdl[k] = '0;
    mdl[0]  = seed0;
    mdl[1]  = seed1;
    mdl_ovf = 1'b0;
  endtask

  task automatic model_run(input int cnt);
    logic [DW:0] s;
    exp_addr.delete(); exp_data.delete(); exp_ovf.delete();
    if (cnt < 2) return;
    mdl_ovf = 1'b0;
    for (int i = 2; i <= cnt; i++) begin
      s = {1'b0, mdl[i-2]} + {1'b0, mdl[i-1]};
      if (s > 33'hFFFF_FFFF) begin
        mdl_ovf = 1'b1;
`ifdef FIB_SAT_EN
        mdl[i] = 32'hFFFF_FFFF;
`else
        mdl[i] = s[DW-1:0];
`endif
      end else begin
        mdl[i] = s[DW-1:0];
      end
      exp_addr.push_back(i);
      exp_data.push_back(mdl[i]);
      exp_ovf.push_back(mdl_ovf);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Launch a run and observe it until a few cycles after done.
  // pulse_at != 0 re-pulses start (with a different count) in that cycle.
  task automatic run_seq(input int cnt, input int pulse_at);
    cap_addr.delete(); cap_data.delete(); cap_ovf.delete();
    busy_cyc = 0; done_n = 0; done_at = 0; ovf_any = 1'b0;
    @(posedge clk); #1;
    bus.count = AW'(cnt);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.overflow === 1'b1) ovf_any = 1'b1;
      if (bus.wEna === 1'b1) begin
        cap_addr.push_back(int'(bus.wAddr));
        cap_data.push_back(bus.wDin);
        cap_ovf.push_back(bus.overflow);
      end
      if (bus.done === 1'b1) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (pulse_at != 0 && c == pulse_at) begin
        bus.start = 1'b1;
        bus.count = AW'(2);
      end else begin
        bus.start = 1'b0;
      end
      if (done_at != 0 && c >= done_at + 3) break;
    end
    bus.start = 1'b0;
    if (done_at == 0) begin
      total++; bad++;
      $display("FAIL run_timeout count=%0d: done not seen within 400 cycles", cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.wEna !== 1'b0)     begin bad++; $display("FAIL rst_wEna got=%0d want=0", bus.wEna); end
    total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%0d want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)     begin bad++; $display("FAIL rst_done got=%0d want=0", bus.done); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0d want=0", bus.overflow); end
    total++; if (bus.rAddr !== '0)      begin bad++; $display("FAIL rst_rAddr got=%0d want=0", bus.rAddr); end
    total++; if (bus.wAddr !== '0)      begin bad++; $display("FAIL rst_wAddr got=%0d want=0", bus.wAddr); end
    total++; if (bus.wDin !== '0)       begin bad++; $display("FAIL rst_wDin got=%0h want=0", bus.wDin); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.wEna !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL idle_after_rst busy=%0d wEna=%0d done=%0d want 0/0/0", bus.busy, bus.wEna, bus.done);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] kv [4];
    kv[0] = 32'd4; kv[1] = 32'd6; kv[2] = 32'd10; kv[3] = 32'd16;
    model_run(5);
    run_seq(5, 0);
    total++; if (cap_addr.size() != exp_addr.size()) begin bad++; $display("FAIL basic_nwrites got=%0d want=%0d", cap_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
      total++; if (cap_addr[k] != exp_addr[k]) begin bad++; $display("FAIL basic_waddr[%0d] got=%0d want=%0d", k, cap_addr[k], exp_addr[k]); end
      total++; if (cap_data[k] !== exp_data[k]) begin bad++; $display("FAIL basic_wdin[%0d] got=%0d want=%0d", k, cap_data[k], exp_data[k]); end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (mem[k+2] !== kv[k]) begin bad++; $display("FAIL basic_reg%0d got=%0d want=%0d", k+2, mem[k+2], kv[k]); end
    end
    total++; if (busy_cyc != 12) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=12", busy_cyc); end
    total++; if (done_n != 1)    begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_n); end
    total++; if (done_at != 13)  begin bad++; $display("FAIL basic_done_cycle got=%0d want=13", done_at); end
    total++; if (ovf_any !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0d want=0", ovf_any); end
  endtask

  task automatic test_short();
    for (int cnt = 0; cnt < 2; cnt++) begin
      model_run(cnt);
      run_seq(cnt, 0);
      total++; if (cap_addr.size() != 0) begin bad++; $display("FAIL short%0d_writes got=%0d want=0", cnt, cap_addr.size()); end
      total++; if (busy_cyc != 0)  begin bad++; $display("FAIL short%0d_busy got=%0d want=0", cnt, busy_cyc); end
      total++; if (done_at != 1)   begin bad++; $display("FAIL short%0d_done_cycle got=%0d want=1", cnt, done_at); end
      total++; if (done_n != 1)    begin bad++; $display("FAIL short%0d_done_pulses got=%0d want=1", cnt, done_n); end
    end
  endtask

  task automatic test_full_overflow();
    int idx46;
    logic [DW-1:0] want46;
`ifdef FIB_SAT_EN
    want46 = 32'hFFFF_FFFF;
`else
    want46 = 32'd1647462850;
`endif
    model_run(63);
    run_seq(63, 0);
    total++; if (cap_addr.size() != 62) begin bad++; $display("FAIL full_nwrites got=%0d want=62", cap_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
      total++; if (cap_addr[k] != exp_addr[k] || cap_data[k] !== exp_data[k] || cap_ovf[k] !== exp_ovf[k]) begin
        bad++; $display("FAIL full_write[%0d] got a=%0d d=%0h o=%0d want a=%0d d=%0h o=%0d",
                        k, cap_addr[k], cap_data[k], cap_ovf[k], exp_addr[k], exp_data[k], exp_ovf[k]);
      end
    end
    total++; if (mem[45] !== 32'd3672623806) begin bad++; $display("FAIL full_reg45 got=%0d want=3672623806", mem[45]); end
    idx46 = -1;
    for (int k = 0; k < cap_addr.size(); k++) if (cap_addr[k] == 46) idx46 = k;
    total++; if (idx46 < 1) begin
      bad++; $display("FAIL full_write46 got=missing want=present");
    end else begin
      total++; if (cap_data[idx46] !== want46) begin bad++; $display("FAIL full_wdin46 got=%0h want=%0h", cap_data[idx46], want46); end
      total++; if (cap_ovf[idx46] !== 1'b1)   begin bad++; $display("FAIL full_ovf_at46 got=%0d want=1", cap_ovf[idx46]); end
      total++; if (cap_ovf[idx46-1] !== 1'b0) begin bad++; $display("FAIL full_ovf_at45 got=%0d want=0", cap_ovf[idx46-1]); end
    end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL full_ovf_sticky got=%0d want=1", bus.overflow); end
    total++; if (busy_cyc != 186) begin bad++; $display("FAIL full_busy_cycles got=%0d want=186", busy_cyc); end
  endtask

  task automatic test_new_run_clears();
    model_run(3);
    run_seq(3, 0);
    total++; if (ovf_any !== 1'b0) begin bad++; $display("FAIL clr_overflow got=%0d want=0", ovf_any); end
    total++; if (mem[2] !== 32'd4 || mem[3] !== 32'd6) begin bad++; $display("FAIL clr_regs got=%0d,%0d want=4,6", mem[2], mem[3]); end
    total++; if (cap_addr.size() != 2) begin bad++; $display("FAIL clr_nwrites got=%0d want=2", cap_addr.size()); end
  endtask

  task automatic test_start_while_busy();
    model_run(10);
    run_seq(10, 4);
    total++; if (busy_cyc != 27) begin bad++; $display("FAIL swb_busy_cycles got=%0d want=27", busy_cyc); end
    total++; if (done_n != 1)    begin bad++; $display("FAIL swb_done_pulses got=%0d want=1", done_n); end
    total++; if (done_at != 28)  begin bad++; $display("FAIL swb_done_cycle got=%0d want=28", done_at); end
    total++; if (cap_addr.size() != exp_addr.size()) begin bad++; $display("FAIL swb_nwrites got=%0d want=%0d", cap_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
      total++; if (cap_addr[k] != exp_addr[k] || cap_data[k] !== exp_data[k]) begin
        bad++; $display("FAIL swb_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", k, cap_addr[k], cap_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    bus.count = AW'(10);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (bus.wEna !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL mid_pre_rst wEna=%0d busy=%0d want 1/1", bus.wEna, bus.busy); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.wEna !== 1'b0) begin bad++; $display("FAIL mid_rst_wEna got=%0d want=0", bus.wEna); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%0d want=0", bus.busy); end
    total++; if (bus.rAddr !== '0 || bus.wAddr !== '0 || bus.wDin !== '0 || bus.done !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL mid_rst_outputs got rA=%0d wA=%0d wD=%0d done=%0d ovf=%0d want all 0",
                      bus.rAddr, bus.wAddr, bus.wDin, bus.done, bus.overflow);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    model_run(3);
    run_seq(3, 0);
    total++; if (mem[2] !== 32'd4) begin bad++; $display("FAIL mid_reg2 got=%0d want=4", mem[2]); end
    total++; if (mem[3] !== 32'd6) begin bad++; $display("FAIL mid_reg3 got=%0d want=6", mem[3]); end
    total++; if (mem[4] !== 32'd0) begin bad++; $display("FAIL mid_reg4 got=%0d want=0", mem[4]); end
  endtask

  task automatic test_random();
    int cnt;
    for (int it = 0; it < 6; it++) begin
      seed0 = $urandom;
      seed1 = $urandom;
      do_reset();
      cnt = int'($urandom_range(63, 2));
      model_run(cnt);
      run_seq(cnt, 0);
      total++; if (cap_addr.size() != exp_addr.size()) begin bad++; $display("FAIL rnd%0d_nwrites got=%0d want=%0d", it, cap_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
        total++; if (cap_addr[k] != exp_addr[k] || cap_data[k] !== exp_data[k] || cap_ovf[k] !== exp_ovf[k]) begin
          bad++; $display("FAIL rnd%0d_write[%0d] got a=%0d d=%0h o=%0d want a=%0d d=%0h o=%0d",
                          it, k, cap_addr[k], cap_data[k], cap_ovf[k], exp_addr[k], exp_data[k], exp_ovf[k]);
        end
      end
      total++; if (busy_cyc != 3 * (cnt - 1)) begin bad++; $display("FAIL rnd%0d_busy got=%0d want=%0d", it, busy_cyc, 3 * (cnt - 1)); end
      total++; if (done_at != 3 * (cnt - 1) + 1) begin bad++; $display("FAIL rnd%0d_done_cycle got=%0d want=%0d", it, done_at, 3 * (cnt - 1) + 1); end
      total++; if (bus.overflow !== mdl_ovf) begin bad++; $display("FAIL rnd%0d_overflow got=%0d want=%0d", it, bus.overflow, mdl_ovf); end
      for (int k = 2; k <= cnt; k++) begin
        total++; if (mem[k] !== mdl[k]) begin bad++; $display("FAIL rnd%0d_reg%0d got=%0h want=%0h", it, k, mem[k], mdl[k]); end
      end
    end
    seed0 = 32'd2;
    seed1 = 32'd2;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_full_overflow();
    test_new_run_clears();
    test_start_while_busy();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
